axis_udp_rx_frame_buffer: RTL and testbench
===========================================

AXIS_UDP_RX_FRAME_BUFFER -- requirements
Module: axis_udp_rx_frame_buffer

Interface
REQ-001 Parameter DEPTH, default 2048, buffer capacity in bytes; SHALL be a power of two, 16 or more.
REQ-002 Parameter ADDR_WIDTH, default $clog2(DEPTH), RAM address width; pointers SHALL be ADDR_WIDTH+1 bits.
REQ-003 Port clk  in  1  clock; all logic SHALL be in the clk domain.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port s_axis_tdata  in  8  UDP payload byte from the UDP stack receive output.
REQ-006 Port s_axis_tvalid  in  1; s_axis_tlast  in  1; s_axis_tuser  in  1  (1 on the tlast beat = bad frame).
REQ-007 Port s_axis_tready  out  1  SHALL be 1 whenever rst=0 (drop-mode sink, never back-pressures).
REQ-008 Port m_axis_tdata  out  8; m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tlast  out  1; m_axis_tuser  out  1 (SHALL be tied 0).
REQ-009 Port frame_count  out  ADDR_WIDTH+1  number of committed frames not yet fully read.
REQ-010 Ports good_frame, bad_frame, overflow  out  1 each  single-cycle status pulses.

Function
REQ-011 Storage: DEPTH x 9-bit RAM {tlast, tdata}; write pointer wr_ptr, commit pointer wr_commit, read pointer rd_ptr.
REQ-012 Full: wr_ptr - rd_ptr == DEPTH (modulo 2^(ADDR_WIDTH+1)). Empty: rd_ptr == wr_commit.
REQ-013 Input beat accepted (tvalid & tready), not full, drop_frame=0: write {tlast,tdata} at wr_ptr, wr_ptr += 1.
REQ-014 Good end (tlast=1, tuser=0, no drop): wr_commit <= wr_ptr+1 the same edge; good_frame pulse next cycle; frame_count +1.
REQ-015 Bad end (tlast=1, tuser=1, no drop): wr_ptr <= wr_commit, nothing committed; bad_frame pulse.
REQ-016 Overflow: beat accepted while full SHALL set drop_frame, pulse overflow once, and discard that and all later beats of the frame.
REQ-017 Dropped-frame end: tlast during drop_frame rewinds wr_ptr <= wr_commit and clears drop_frame; no good_frame/bad_frame pulse.
REQ-018 Frame longer than DEPTH bytes SHALL always overflow and be dropped; other frames SHALL be unaffected.
REQ-019 Output: single output register stage; RAM read when rd_ptr != wr_commit and (m_axis_tvalid=0 or m_axis_tready=1).
REQ-020 Latency: with the output idle and the buffer empty, m_axis_tvalid SHALL rise exactly 2 cycles after the committing tlast handshake.
REQ-021 Throughput: with m_axis_tready=1 throughout, one byte per cycle, no bubbles within or between committed frames.
REQ-022 m_axis_tdata/tlast SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 frame_count SHALL decrement on the output handshake of a beat with m_axis_tlast=1; simultaneous commit and output tlast leave it unchanged.
REQ-024 Simultaneous write and read in one cycle SHALL both take effect; pointers wrap modulo 2^(ADDR_WIDTH+1).
REQ-025 Uncommitted bytes SHALL never be visible at the output; a partially received frame is invisible.

Reset
REQ-026 On rst=1: wr_ptr, wr_commit, rd_ptr, frame_count, drop_frame <= 0; m_axis_tvalid, m_axis_tlast, good_frame, bad_frame, overflow <= 0; s_axis_tready <= 0.
REQ-027 Reset mid-frame (input or output) SHALL discard all buffered and in-flight data; RAM contents need not be cleared.
REQ-028 First cycle after rst deasserts: s_axis_tready=1, buffer empty.

Verification
REQ-029 Single 4-byte good frame 0x11,0x22,0x33,0x44, m_axis_tready=1 -> good_frame pulse; m_axis_tvalid 2 cycles after tlast; same 4 bytes out, tlast on 0x44; frame_count 1 then 0.
REQ-030 Bad frame (5 bytes, tuser=1 on tlast) then good 3-byte frame 0xA0..0xA2 -> bad_frame pulse; output contains only 0xA0,0xA1,0xA2.
REQ-031 DEPTH=16, 20-byte frame followed by 8-byte frame -> overflow pulses once; only the 8-byte frame emerges; frame_count peaks at 1.
REQ-032 Three 6-byte frames, m_axis_tready=0 until all committed -> frame_count=3; then random tready back-pressure -> 18 bytes out in order, data held stable while stalled.
REQ-033 Continuous 64-byte frames for 10*DEPTH bytes, tready=1 -> no drops, pointer wrap verified, no output bubbles.
REQ-034 rst asserted mid-output of a 10-byte frame -> next cycle m_axis_tvalid=0, frame_count=0; subsequent good frame passes intact.

Source files
------------

// File: rtl/axis_udp_rx_frame_buffer.sv
// ---------------------------------------------------------------------------
// axis_udp_rx_frame_buffer
//
// Store-and-forward frame buffer that sits behind a UDP stack's receive
// AXI-Stream output. Bytes are written into a circular RAM as they arrive.
// They become visible to the output only after the frame's tlast beat
// arrives with tuser=0 (a good frame). Bad frames are rewound. Frames that
// do not fit are dropped whole. The input never back-pressures: a full
// buffer discards data instead of stalling the UDP stack.
//
// Parameters
//   DEPTH       buffer capacity in bytes (power of two, >= 16)
//   ADDR_WIDTH  RAM address width; pointers carry one extra wrap bit
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   s_axis_*          input stream (tdata/tvalid/tready/tlast/tuser)
//   m_axis_*          output stream (tdata/tvalid/tready/tlast/tuser=0)
//   frame_count       committed frames whose tlast has not yet left
//   good_frame        1-cycle pulse: frame committed
//   bad_frame         1-cycle pulse: frame ended with tuser=1, discarded
//   overflow          1-cycle pulse: frame hit a full buffer, being dropped
// ---------------------------------------------------------------------------
module axis_udp_rx_frame_buffer #(
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,

  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,

  output logic [ADDR_WIDTH:0]   frame_count,
  output logic                  good_frame,
  output logic                  bad_frame,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;

  // {tlast, tdata} per entry
  logic [8:0]    mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_commit;
  logic [PW-1:0] rd_ptr;
  // Commit pointer as seen by the read side, one cycle behind wr_commit.
  // This sets the commit-to-tvalid latency to two cycles. It also means a
  // byte is never read in the cycle right after its commit write.
  logic [PW-1:0] rd_limit;
  logic          drop_frame;

  logic          in_beat;
  logic          full;
  logic          wr_en;
  logic          commit_ev;
  logic          rd_en;
  logic          out_last_hs;
  logic [8:0]    rd_word;

  // The sink never stalls; it only goes low while reset is held.
  assign s_axis_tready = ~rst;
  assign m_axis_tuser  = 1'b0;

  always_comb begin
    in_beat     = s_axis_tvalid & s_axis_tready;
    full        = (wr_ptr - rd_ptr) == PW'(DEPTH);
    wr_en       = in_beat & ~drop_frame & ~full;
    commit_ev   = wr_en & s_axis_tlast & ~s_axis_tuser;
    rd_en       = (rd_ptr != rd_limit) & (~m_axis_tvalid | m_axis_tready);
    out_last_hs = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    rd_word     = mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  // RAM write port. No reset: stale contents are never exposed because
  // the read side is bounded by the commit pointer.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  // ---------------- write side ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      wr_commit  <= '0;
      drop_frame <= 1'b0;
      good_frame <= 1'b0;
      bad_frame  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      good_frame <= 1'b0;
      bad_frame  <= 1'b0;
      overflow   <= 1'b0;
      if (in_beat) begin
        if (drop_frame) begin
          // Drop the rest of an overflowed frame. At its tlast, rewind
          // over the partial data and re-arm. No status pulse here.
          if (s_axis_tlast) begin
            wr_ptr     <= wr_commit;
            drop_frame <= 1'b0;
          end
        end else if (full) begin
          overflow <= 1'b1;
          // An overflowing tlast beat ends the frame on the spot.
          if (s_axis_tlast)
            wr_ptr <= wr_commit;
          else
            drop_frame <= 1'b1;
        end else if (s_axis_tlast) begin
          if (s_axis_tuser) begin
            wr_ptr    <= wr_commit;
            bad_frame <= 1'b1;
          end else begin
            wr_ptr     <= wr_ptr + 1'b1;
            wr_commit  <= wr_ptr + 1'b1;
            good_frame <= 1'b1;
          end
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

  // ---------------- read side ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      rd_limit      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      rd_limit <= wr_commit;
      if (rd_en) begin
        m_axis_tdata  <= rd_word[7:0];
        m_axis_tlast  <= rd_word[8];
        m_axis_tvalid <= 1'b1;
        rd_ptr        <= rd_ptr + 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  // ---------------- frame count ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
    end else begin
      case ({commit_ev, out_last_hs})
        2'b10:   frame_count <= frame_count + 1'b1;
        2'b01:   frame_count <= frame_count - 1'b1;
        default: frame_count <= frame_count;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_udp_rx_frame_buffer.sv
// Directed bench. It drives a DEPTH=16 instance (u_s) and a DEPTH=128
// instance (u_b) from the same input stream, and each test checks one of them.
module tb_axis_udp_rx_frame_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tlast, s_tuser;
  logic       m_tready;

  logic       s_sr, s_mv, s_ml, s_mu, s_good, s_bad, s_ovf;
  logic [7:0] s_md;
  logic [4:0] s_fc;
  logic       b_sr, b_mv, b_ml, b_mu, b_good, b_bad, b_ovf;
  logic [7:0] b_md;
  logic [7:0] b_fc;

  int total = 0;
  int bad   = 0;

  logic [8:0] q_s[$];
  logic [8:0] q_b[$];
  int ovf_s = 0, good_s = 0, bad_s = 0, fcmax_s = 0;
  int ovf_b = 0, good_b = 0;
  int cyc = 0, hs_first = 0, hs_last = 0;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_word  = '0;

  always #5 clk = ~clk;

  axis_udp_rx_frame_buffer #(.DEPTH(16)) u_s (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_sr),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(s_md), .m_axis_tvalid(s_mv), .m_axis_tready(m_tready),
    .m_axis_tlast(s_ml), .m_axis_tuser(s_mu),
    .frame_count(s_fc), .good_frame(s_good), .bad_frame(s_bad), .overflow(s_ovf)
  );

  axis_udp_rx_frame_buffer #(.DEPTH(128)) u_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(b_sr),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(b_md), .m_axis_tvalid(b_mv), .m_axis_tready(m_tready),
    .m_axis_tlast(b_ml), .m_axis_tuser(b_mu),
    .frame_count(b_fc), .good_frame(b_good), .bad_frame(b_bad), .overflow(b_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitors sample at the falling edge, so they see the values that
  // the next rising edge will act on.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (s_mv && m_tready) q_s.push_back({s_ml, s_md});
      if (s_ovf)  ovf_s++;
      if (s_good) good_s++;
      if (s_bad)  bad_s++;
      if (int'(s_fc) > fcmax_s) fcmax_s = int'(s_fc);
      if (b_ovf)  ovf_b++;
      if (b_good) good_b++;
      if (prev_stall) chk("hold_stable", {22'd0, b_mv, b_ml, b_md}, {22'd0, prev_word});
      if (b_mv && m_tready) begin
        if (q_b.size() == 0) hs_first = cyc;
        hs_last = cyc;
        q_b.push_back({b_ml, b_md});
      end
      prev_stall = b_mv && !m_tready;
      prev_word  = {b_mv, b_ml, b_md};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tdata = '0;
    repeat (2) tick();
    rst = 1'b0;
    q_s.delete();
    q_b.delete();
    fcmax_s = 0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] start,
                            input logic [7:0] step, input logic user);
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = start + 8'(i) * step;
      s_tlast  = (i == n - 1);
      s_tuser  = user && (i == n - 1);
      tick();
    end
  endtask

  initial begin
    int errs, o0, g0, b0, go0;
    rst = 1'b1; m_tready = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tdata = '0;

    // ---- reset state ----
    repeat (3) tick();
    @(negedge clk);
    chk("rst_sready", {31'd0, s_sr}, 32'd0);
    chk("rst_outputs", {s_mv, s_ml, s_good, s_bad, s_ovf, s_fc}, '0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_sready", {31'd0, s_sr}, 32'd1);
    chk("post_rst_empty", {s_mv, s_fc}, '0);

    // ---- single 4-byte good frame, latency ----
    do_reset();
    send_frame(4, 8'h11, 8'h11, 1'b0);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    @(negedge clk);
    chk("t29_good_pulse", {s_good, s_mv, s_fc}, {2'b10, 5'd1});
    @(negedge clk);
    chk("t29_good_single", {s_good, s_mv}, 2'b00);
    @(negedge clk);
    chk("t29_tvalid_rise", {s_mv, s_md}, {1'b1, 8'h11});
    chk("t29_tuser", {31'd0, s_mu}, 32'd0);
    repeat (8) tick();
    chk("t29_count", q_s.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t29_byte", 32'(q_s[i]), {23'd0, (i == 3), 8'(8'h11 * (i + 1))});
    chk("t29_fc_zero", {27'd0, s_fc}, 32'd0);

    // ---- bad frame then good frame ----
    do_reset();
    send_frame(5, 8'hB0, 8'h01, 1'b1);
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    @(negedge clk);
    chk("t30_bad_pulse", {s_bad, s_good}, 2'b10);
    tick();
    send_frame(3, 8'hA0, 8'h01, 1'b0);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (10) tick();
    chk("t30_count", q_s.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("t30_byte", 32'(q_s[i]), {23'd0, (i == 2), 8'(8'hA0 + i)});

    // ---- overflow on DEPTH=16 ----
    do_reset();
    o0 = ovf_s; g0 = good_s; b0 = bad_s;
    send_frame(20, 8'h00, 8'h01, 1'b0);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    tick();
    send_frame(8, 8'h80, 8'h01, 1'b0);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (15) tick();
    chk("t31_ovf_once", ovf_s - o0, 1);
    chk("t31_good_cnt", good_s - g0, 1);
    chk("t31_bad_cnt", bad_s - b0, 0);
    chk("t31_fc_peak", fcmax_s, 1);
    chk("t31_count", q_s.size(), 8);
    errs = 0;
    for (int i = 0; i < 8; i++)
      if (q_s[i] !== {(i == 7), 8'(8'h80 + i)}) errs++;
    chk("t31_data", errs, 0);

    // ---- three frames stalled, then random back-pressure ----
    do_reset();
    m_tready = 1'b0;
    send_frame(6, 8'h10, 8'h01, 1'b0);
    send_frame(6, 8'h20, 8'h01, 1'b0);
    send_frame(6, 8'h30, 8'h01, 1'b0);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t32_fc3", {24'd0, b_fc}, 32'd3);
    chk("t32_head", {b_mv, b_md}, {1'b1, 8'h10});
    tick();
    for (int i = 0; i < 400 && q_b.size() < 18; i++) begin
      m_tready = 1'($urandom_range(0, 1));
      tick();
    end
    m_tready = 1'b1;
    repeat (3) tick();
    chk("t32_count", q_b.size(), 18);
    errs = 0;
    for (int i = 0; i < 18; i++)
      if (q_b[i] !== {(i % 6 == 5), 8'(8'h10 * (i / 6 + 1) + i % 6)}) errs++;
    chk("t32_order", errs, 0);
    chk("t32_fc0", {24'd0, b_fc}, 32'd0);

    // ---- continuous 64-byte frames, 10*DEPTH bytes on DEPTH=128 ----
    do_reset();
    o0 = ovf_b; go0 = good_b;
    for (int f = 0; f < 20; f++)
      send_frame(64, 8'(f * 64), 8'h01, 1'b0);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    for (int i = 0; i < 300 && q_b.size() < 1280; i++) tick();
    chk("t33_count", q_b.size(), 1280);
    errs = 0;
    for (int i = 0; i < 1280; i++)
      if (q_b[i] !== {(i % 64 == 63), 8'(i)}) errs++;
    chk("t33_data", errs, 0);
    chk("t33_no_ovf", ovf_b - o0, 0);
    chk("t33_good_cnt", good_b - go0, 20);
    chk("t33_no_bubble", hs_last - hs_first, 1279);

    // ---- reset mid-output ----
    do_reset();
    send_frame(10, 8'h50, 8'h01, 1'b0);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    for (int i = 0; i < 50 && q_s.size() < 3; i++) tick();
    chk("t34_started", q_s.size() >= 3, 1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t34_flushed", {s_mv, s_fc}, '0);
    tick();
    rst = 1'b0;
    q_s.delete();
    tick();
    send_frame(4, 8'h60, 8'h01, 1'b0);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (10) tick();
    chk("t34_count", q_s.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t34_byte", 32'(q_s[i]), {23'd0, (i == 3), 8'(8'h60 + i)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
